rv32_mod_dmem_responder: RTL and testbench
==========================================

// Module: rv32_mod_dmem_responder
// PURPOSE
//  Responder (slave) end of the hart data bus (dext_*) driven by the load/store unit. Backs the
//  bus with a word-organised SRAM array, with byte-enable writes and a fixed, configurable
//  number of wait states. Returns full 32-bit words; byte/half extraction and sign extension
//  stay in the LSU. Flags illegal accesses with a one-cycle dext_err instead of dext_ack.
// PARAMETERS
//  DEPTH        1024          number of 32-bit words; power of two, >= 4
//  BASE_ADDR    32'h0000_0000 byte address of word 0; DEPTH*4-aligned
//  WAIT_STATES  0             extra cycles between request capture and response, 0..15
//  INIT_FILE    ""            $readmemh image loaded at elaboration; "" means contents undefined
// PORTS
//  clk          in   1   clock; all logic on rising edge
//  reset        in   1   synchronous, active-low reset
//  dext_req     in   1   one-cycle request strobe; addr/wr/be/do are valid in the strobe cycle
//  dext_wr      in   1   1 = write, 0 = read
//  dext_be      in   4   byte enables; bit i selects data[8i+7:8i]
//  dext_addr    in   32  byte address, word-aligned
//  dext_do      in   32  write data from the initiator
//  dext_ack     out  1   one-cycle success response
//  dext_err     out  1   one-cycle error response; never high together with dext_ack
//  dext_di      out  32  read data; valid only in the dext_ack cycle of a read, else 32'h0
//  proto_err    out  1   sticky: dext_req seen while busy; cleared only by reset
// BEHAVIOUR
//  Reset (reset==0 at a clock edge): FSM to IDLE; dext_ack=0, dext_err=0, dext_di=0,
//   proto_err=0, wait counter=0. Array contents are not cleared. A transaction in flight when
//   reset is asserted is dropped with no response. A write already committed stays committed.
//  FSM states IDLE, WAIT, RESP:
//   IDLE: dext_req=1 -> capture addr/wr/be/do/legality; go WAIT if WAIT_STATES>0, else RESP.
//   WAIT: counter counts 1..WAIT_STATES; at WAIT_STATES go RESP.
//   RESP: dext_ack or dext_err is high for exactly this cycle. dext_req=1 here is accepted as a
//    new request (same rules as IDLE), so back-to-back traffic is supported; else go IDLE.
//  Latency: with the request strobe in cycle N, the response occurs in cycle N+1+WAIT_STATES.
//   Back-to-back throughput is one access per 1+WAIT_STATES cycles.
//  dext_req=1 in WAIT, or in IDLE->RESP transition cycles other than those above: the request
//   is ignored (no capture, no response) and proto_err is set. The current transaction is
//   unaffected.
//  Legality, evaluated on the captured request. Error if any of:
//   - addr[1:0] != 0
//   - addr outside [BASE_ADDR, BASE_ADDR+DEPTH*4-1]; compute as 33-bit, no wrap at 2^32
//   - be not in {0001,0010,0100,1000,0011,1100,1111}; this includes be=0000
//  On error: no array write; dext_err=1, dext_ack=0, dext_di=0 in the response cycle.
//  Word index = (addr - BASE_ADDR) >> 2, truncated to $clog2(DEPTH) bits.
//  Write: in the response cycle, mem[idx] byte i <= do byte i for each set be[i]; other bytes
//   are unchanged. dext_di=0.
//  Read: dext_di = full mem[idx] word, regardless of be; registered; valid in the ack cycle.
//  Read-after-write to the same word in consecutive transactions returns the new data.
//  Outputs are registered; no combinational path from inputs to outputs.
// TESTING
//  T1 WAIT_STATES=0: write addr=0x10 be=1111 do=0xDEADBEEF, then read 0x10 ->
//   ack one cycle after each req; read dext_di=0xDEADBEEF.
//  T2 byte-enable merge: after T1, write 0x10 be=0100 do=0x00AA0000, then read ->
//   0xDEAABEEF; write be=0011 do=0x1234 -> reading back gives 0xDEAA1234.
//  T3 WAIT_STATES=3: req in cycle 5 -> ack exactly in cycle 9, ack low in cycles 6-8;
//   req during cycle 7 -> proto_err=1 stays set, and only one ack is issued.
//  T4 errors: read addr=0x12; addr=BASE_ADDR+DEPTH*4; write be=0101 -> each gives dext_err for
//   one cycle, ack=0, di=0, and target words unchanged on read-back.
//  T5 back-to-back, WAIT_STATES=0: req in every cycle 0..3 (wr,rd,wr,rd) -> ack in cycles 1..4,
//   proto_err=0, each read returns the preceding write data.
//  T6 reset mid-transaction: WAIT_STATES=2, read req, then reset low in the next cycle ->
//   no ack/err, all outputs 0; after reset release, a new read completes normally.

Source files
------------

// File: rtl/rv32_mod_dmem_responder_if.sv
// Hart data bus (dext_*) between the load/store unit (master) and a memory responder (slave).
interface rv32_mod_dmem_responder_if;
    logic        dext_req;
    logic        dext_wr;
    logic [3:0]  dext_be;
    logic [31:0] dext_addr;
    logic [31:0] dext_do;
    logic        dext_ack;
    logic        dext_err;
    logic [31:0] dext_di;
    logic        proto_err;

    modport master (
        output dext_req, dext_wr, dext_be, dext_addr, dext_do,
        input  dext_ack, dext_err, dext_di, proto_err
    );

    modport slave (
        input  dext_req, dext_wr, dext_be, dext_addr, dext_do,
        output dext_ack, dext_err, dext_di, proto_err
    );
endinterface

// File: rtl/rv32_mod_dmem_responder.sv
// Data-bus responder: word SRAM with byte-enable writes, fixed wait states and
// one-cycle ack/err responses. Full words are returned; lane extraction is the LSU's job.
module rv32_mod_dmem_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic                        clk,
    input  logic                        reset,
    rv32_mod_dmem_responder_if.slave    dext
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam logic [32:0] BASE33 = {1'b0, BASE_ADDR};
    localparam logic [32:0] LIMIT  = BASE33 + (33'(DEPTH) * 33'd4);
    localparam logic [3:0]  WS     = 4'(WAIT_STATES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [31:0] mem [DEPTH];

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   do_q, do_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          bad_q, bad_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [31:0]   di_q, di_d;
    logic          perr_q, perr_d;

    logic          be_ok, in_bad;
    logic [32:0]   in_addr33;
    logic [AW-1:0] in_idx;
    logic          fire, f_wr, f_bad;
    logic [3:0]    f_be;
    logic [31:0]   f_do;
    logic [AW-1:0] f_idx;

    // Legality of the request presented on the bus this cycle.
    always_comb begin
        case (dext.dext_be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111: be_ok = 1'b1;
            default: be_ok = 1'b0;
        endcase
        in_addr33 = {1'b0, dext.dext_addr};
        in_idx    = AW'((dext.dext_addr - BASE_ADDR) >> 2);
        in_bad    = (dext.dext_addr[1:0] != 2'b00) || (in_addr33 < BASE33) ||
                    (in_addr33 >= LIMIT) || !be_ok;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        be_d    = be_q;
        do_d    = do_q;
        idx_d   = idx_q;
        bad_d   = bad_q;
        perr_d  = perr_q;
        fire    = 1'b0;
        f_wr    = wr_q;
        f_be    = be_q;
        f_do    = do_q;
        f_idx   = idx_q;
        f_bad   = bad_q;
        case (state_q)
            ST_WAIT: begin
                perr_d = perr_q | dext.dext_req;
                if (cnt_q == WS) begin
                    fire    = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (dext.dext_req) begin
                    wr_d  = dext.dext_wr;
                    be_d  = dext.dext_be;
                    do_d  = dext.dext_do;
                    idx_d = in_idx;
                    bad_d = in_bad;
                    if (WAIT_STATES == 0) begin
                        // Zero wait states: respond straight from the bus, bypassing capture.
                        fire    = 1'b1;
                        f_wr    = dext.dext_wr;
                        f_be    = dext.dext_be;
                        f_do    = dext.dext_do;
                        f_idx   = in_idx;
                        f_bad   = in_bad;
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = 4'd1;
                        state_d = ST_WAIT;
                    end
                end
            end
        endcase
        ack_d = fire & ~f_bad;
        err_d = fire & f_bad;
        di_d  = (fire && !f_bad && !f_wr) ? mem[f_idx] : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            be_q    <= 4'd0;
            do_q    <= 32'h0;
            idx_q   <= '0;
            bad_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            di_q    <= 32'h0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            be_q    <= be_d;
            do_q    <= do_d;
            idx_q   <= idx_d;
            bad_q   <= bad_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            di_q    <= di_d;
            perr_q  <= perr_d;
        end
    end

    // The write commits on the edge that opens the response cycle, so the next access sees it.
    always_ff @(posedge clk) begin
        if (reset && fire && !f_bad && f_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (f_be[i]) mem[f_idx][8*i +: 8] <= f_do[8*i +: 8];
            end
        end
    end

    assign dext.dext_ack  = ack_q;
    assign dext.dext_err  = err_q;
    assign dext.dext_di   = di_q;
    assign dext.proto_err = perr_q;

endmodule

// File: tb/tb_rv32_mod_dmem_responder.sv
// Scoreboard bench: three responders (0, 3 and 2 wait states, different bases) share one
// stimulus bus with per-instance request strobes; expected responses come from a memory model.
module tb_rv32_mod_dmem_responder;

    typedef struct packed {
        logic        ack;
        logic        err;
        logic [31:0] di;
    } resp_t;

    typedef struct packed {
        logic        wr;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] data;
    } op_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ack, err, perr;
    logic [31:0] di [3];

    int n_checks = 0;
    int n_fail   = 0;

    resp_t       exp_q [$];
    logic [31:0] ref_mem [3][64];

    always #5 clk = ~clk;

    rv32_mod_dmem_responder_if bus0 ();
    rv32_mod_dmem_responder_if bus1 ();
    rv32_mod_dmem_responder_if bus2 ();

    assign bus0.dext_req = req[0];
    assign bus1.dext_req = req[1];
    assign bus2.dext_req = req[2];
    assign bus0.dext_wr = wr;  assign bus1.dext_wr = wr;  assign bus2.dext_wr = wr;
    assign bus0.dext_be = be;  assign bus1.dext_be = be;  assign bus2.dext_be = be;
    assign bus0.dext_addr = addr;  assign bus1.dext_addr = addr;  assign bus2.dext_addr = addr;
    assign bus0.dext_do = wdata;  assign bus1.dext_do = wdata;  assign bus2.dext_do = wdata;
    assign ack  = {bus2.dext_ack, bus1.dext_ack, bus0.dext_ack};
    assign err  = {bus2.dext_err, bus1.dext_err, bus0.dext_err};
    assign perr = {bus2.proto_err, bus1.proto_err, bus0.proto_err};
    assign di[0] = bus0.dext_di;
    assign di[1] = bus1.dext_di;
    assign di[2] = bus2.dext_di;

    rv32_mod_dmem_responder #(
        .DEPTH(64), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0), .INIT_FILE("")
    ) u_dut0 (.clk(clk), .reset(reset), .dext(bus0));

    rv32_mod_dmem_responder #(
        .DEPTH(64), .BASE_ADDR(32'hFFFF_FF00), .WAIT_STATES(3), .INIT_FILE("")
    ) u_dut1 (.clk(clk), .reset(reset), .dext(bus1));

    rv32_mod_dmem_responder #(
        .DEPTH(64), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(2), .INIT_FILE("")
    ) u_dut2 (.clk(clk), .reset(reset), .dext(bus2));

    function automatic logic [31:0] base_of(input int i);
        case (i)
            1:       return 32'hFFFF_FF00;
            2:       return 32'h0000_1000;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Reference model: decides legality and tracks memory contents.
    task automatic predict(input int i, input op_t op, output resp_t r);
        logic [32:0] a, b;
        logic        bad;
        int          idx;
        a   = {1'b0, op.addr};
        b   = {1'b0, base_of(i)};
        bad = (op.addr[1:0] != 2'b00) || (a < b) || (a >= b + 33'd256) ||
              !(op.be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
        idx = int'((op.addr - base_of(i)) >> 2) & 63;
        if (bad) begin
            r = '{ack: 1'b0, err: 1'b1, di: 32'h0};
        end else if (op.wr) begin
            for (int k = 0; k < 4; k++)
                if (op.be[k]) ref_mem[i][idx][8*k +: 8] = op.data[8*k +: 8];
            r = '{ack: 1'b1, err: 1'b0, di: 32'h0};
        end else begin
            r = '{ack: 1'b1, err: 1'b0, di: ref_mem[i][idx]};
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        req = 3'b000;
    endtask

    task automatic issue(input int i, input op_t op);
        req[i] = 1'b1;
        wr     = op.wr;
        be     = op.be;
        addr   = op.addr;
        wdata  = op.data;
    endtask

    task automatic wait_resp(input int i, output logic got, output resp_t obs, output int lat);
        got = 1'b0;
        obs = '0;
        lat = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            step();
            lat++;
            if (ack[i] || err[i]) begin
                got = 1'b1;
                obs = {ack[i], err[i], di[i]};
            end
        end
    endtask

    task automatic do_op(input int i, input op_t op, output logic got, output resp_t obs,
                         output int lat);
        resp_t e;
        issue(i, op);
        predict(i, op, e);
        exp_q.push_back(e);
        wait_resp(i, got, obs, lat);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({ack[i], err[i], di[i], perr[i]} !== 35'h0) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: got ack=%b err=%b di=%h perr=%b, expected all 0",
                         i, ack[i], err[i], di[i], perr[i]);
            end
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_write_read();
        op_t ops [2];
        logic got; resp_t obs, e; int lat;
        ops = '{'{1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF}, '{1'b0, 4'hF, 32'h10, 32'h0}};
        for (int k = 0; k < 2; k++) begin
            do_op(0, ops[k], got, obs, lat);
            e = exp_q.pop_front();
            n_checks++;
            if (!got || lat != 1 || obs !== e) begin
                n_fail++;
                $display("FAIL write_read[%0d]: got seen=%b lat=%0d resp=%h, expected lat=1 resp=%h",
                         k, got, lat, obs, e);
            end
        end
        n_checks++;
        if (obs.di !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL write_read_data: got %h, expected deadbeef", obs.di);
        end
    endtask

    task automatic test_byte_merge();
        op_t ops [4];
        logic got; resp_t obs, e; int lat;
        ops = '{'{1'b1, 4'b0100, 32'h10, 32'h00AA_0000}, '{1'b0, 4'hF, 32'h10, 32'h0},
                '{1'b1, 4'b0011, 32'h10, 32'h0000_1234}, '{1'b0, 4'hF, 32'h10, 32'h0}};
        for (int k = 0; k < 4; k++) begin
            do_op(0, ops[k], got, obs, lat);
            e = exp_q.pop_front();
            n_checks++;
            if (!got || lat != 1 || obs !== e) begin
                n_fail++;
                $display("FAIL byte_merge[%0d]: got seen=%b lat=%0d resp=%h, expected lat=1 resp=%h",
                         k, got, lat, obs, e);
            end
            if (k == 1 || k == 3) begin
                n_checks++;
                if (obs.di !== ((k == 1) ? 32'hDEAA_BEEF : 32'hDEAA_1234)) begin
                    n_fail++;
                    $display("FAIL byte_merge_data[%0d]: got %h", k, obs.di);
                end
            end
        end
    endtask

    task automatic test_wait_states();
        op_t ops [5];
        op_t rd, ignored;
        logic got; resp_t obs, e; int lat, extra;
        ops = '{'{1'b1, 4'hF, 32'hFFFF_FF40, 32'h1357_9BDF},
                '{1'b1, 4'hF, 32'hFFFF_FFFC, 32'h2468_ACE0},
                '{1'b0, 4'hF, 32'h0000_0000, 32'h0},
                '{1'b0, 4'hF, 32'hFFFF_FEFC, 32'h0},
                '{1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0}};
        for (int k = 0; k < 5; k++) begin
            do_op(1, ops[k], got, obs, lat);
            e = exp_q.pop_front();
            n_checks++;
            if (!got || lat != 4 || obs !== e) begin
                n_fail++;
                $display("FAIL wait3[%0d]: got seen=%b lat=%0d resp=%h, expected lat=4 resp=%h",
                         k, got, lat, obs, e);
            end
        end
        // A request two cycles into the wait must be dropped and flagged.
        rd      = '{1'b0, 4'hF, 32'hFFFF_FF40, 32'h0};
        ignored = '{1'b1, 4'hF, 32'hFFFF_FF40, 32'h0000_0000};
        issue(1, rd);
        predict(1, rd, e);
        exp_q.push_back(e);
        step();
        step();
        issue(1, ignored);
        wait_resp(1, got, obs, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (!got || lat + 2 != 4 || obs !== e) begin
            n_fail++;
            $display("FAIL busy_req_resp: got seen=%b lat=%0d resp=%h, expected lat=4 resp=%h",
                     got, lat + 2, obs, e);
        end
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (ack[1] || err[1]) extra++;
        end
        n_checks++;
        if (extra != 0 || perr[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_req_flag: got extra=%0d perr=%b, expected extra=0 perr=1",
                     extra, perr[1]);
        end
        do_op(1, rd, got, obs, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (!got || lat != 4 || obs !== e) begin
            n_fail++;
            $display("FAIL busy_req_nowrite: got seen=%b lat=%0d resp=%h, expected lat=4 resp=%h",
                     got, lat, obs, e);
        end
    endtask

    task automatic test_errors();
        op_t ops [11];
        logic got; resp_t obs, e; int lat;
        ops = '{'{1'b1, 4'hF, 32'h20, 32'hCAFE_F00D}, '{1'b1, 4'hF, 32'hFC, 32'h0BAD_C0DE},
                '{1'b0, 4'hF, 32'h12, 32'h0}, '{1'b0, 4'hF, 32'h100, 32'h0},
                '{1'b1, 4'hF, 32'h100, 32'h1111_1111},
                '{1'b1, 4'b0101, 32'h20, 32'hFFFF_FFFF}, '{1'b1, 4'b0000, 32'h20, 32'hFFFF_FFFF},
                '{1'b1, 4'hF, 32'h22, 32'h2222_2222}, '{1'b0, 4'hF, 32'h20, 32'h0},
                '{1'b0, 4'hF, 32'hFC, 32'h0}, '{1'b0, 4'b0001, 32'h20, 32'h0}};
        for (int k = 0; k < 11; k++) begin
            do_op(0, ops[k], got, obs, lat);
            e = exp_q.pop_front();
            n_checks++;
            if (!got || lat != 1 || obs !== e) begin
                n_fail++;
                $display("FAIL errors[%0d]: got seen=%b lat=%0d resp=%h, expected lat=1 resp=%h",
                         k, got, lat, obs, e);
            end
        end
        n_checks++;
        if (obs.di !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL errors_unchanged: got %h, expected cafef00d", obs.di);
        end
    endtask

    task automatic test_back_to_back();
        op_t ops [4];
        resp_t obs, e;
        ops = '{'{1'b1, 4'hF, 32'h30, 32'hA5A5_0001}, '{1'b0, 4'hF, 32'h30, 32'h0},
                '{1'b1, 4'hF, 32'h34, 32'h5A5A_0002}, '{1'b0, 4'hF, 32'h34, 32'h0}};
        issue(0, ops[0]);
        predict(0, ops[0], e);
        exp_q.push_back(e);
        for (int k = 0; k < 4; k++) begin
            step();
            obs = {ack[0], err[0], di[0]};
            e   = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got resp=%h, expected resp=%h", k, obs, e);
            end
            if (k < 3) begin
                issue(0, ops[k + 1]);
                predict(0, ops[k + 1], e);
                exp_q.push_back(e);
            end
        end
        step();
        n_checks++;
        if (perr[0] !== 1'b0 || ack[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back_tail: got perr=%b ack=%b, expected 0 0", perr[0], ack[0]);
        end
    endtask

    task automatic test_reset_mid();
        op_t wop, rop;
        logic got; resp_t obs, e; int lat, stray;
        wop = '{1'b1, 4'hF, 32'h0000_1008, 32'h7766_5544};
        rop = '{1'b0, 4'hF, 32'h0000_1008, 32'h0};
        do_op(2, wop, got, obs, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (!got || lat != 3 || obs !== e) begin
            n_fail++;
            $display("FAIL reset_mid_setup: got seen=%b lat=%0d resp=%h, expected lat=3 resp=%h",
                     got, lat, obs, e);
        end
        issue(2, rop);
        step();
        reset = 1'b0;
        stray = 0;
        for (int k = 0; k < 2; k++) begin
            step();
            if ({ack[2], err[2], di[2], perr[2]} !== 35'h0) stray++;
        end
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            if ({ack[2], err[2], di[2], perr[2]} !== 35'h0) stray++;
        end
        n_checks++;
        if (stray != 0 || perr[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_drop: got stray=%0d perr1=%b, expected 0 0", stray, perr[1]);
        end
        do_op(2, rop, got, obs, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (!got || lat != 3 || obs !== e || obs.di !== 32'h7766_5544) begin
            n_fail++;
            $display("FAIL reset_mid_after: got seen=%b lat=%0d resp=%h, expected lat=3 resp=%h",
                     got, lat, obs, e);
        end
    endtask

    initial begin
        reset = 1'b0;
        req   = 3'b000;
        wr    = 1'b0;
        be    = 4'h0;
        addr  = 32'h0;
        wdata = 32'h0;
        test_reset();
        test_write_read();
        test_byte_merge();
        test_wait_states();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule
